// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states, ALU opcodes, legality check.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ALU function codes carried in opcode bits [3:0]
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_AND  = 4'd11;

  // Immediate-operand flag; does not affect legality
  localparam int OP_IMM = 9;

  // Bit 9 (OP_IMM) is a don't-care for legality, so only bits [8:0] are inspected.
  function automatic logic op_is_legal(input logic [8:0] op);
    logic [3:0] fn;
    fn = op[3:0];
    op_is_legal = (op[8:4] == 5'd0) &&
                  (fn inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                              OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND});
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way request arbiter, one-hot grant; round-robin tie break when ALU_ARB_RR_EN is defined, else requester 0 wins ties.
// Latency: combinational grant; tie pointer updates on the clock edge of each grant.
// Backpressure: grants only while en is high; no internal queuing.
module alu_arb_rr (
`ifdef ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  // prio names the requester that wins the next tie
  logic prio;

  // pointer moves to the requester not just granted; reset favours requester 0
  always_ff @(posedge clk) begin
    if (reset)
      prio <= 1'b0;
    else if (|gnt)
      prio <= gnt[0];
  end

  // one-hot grant, tie resolved by the pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11)
        gnt = prio ? 2'b10 : 2'b01;
      else
        gnt = req;
    end
  end
`else
  // one-hot grant, requester 0 always wins a tie
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])
        gnt = 2'b01;
      else if (req[1])
        gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_arb_ctrl.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP); tie policy set by ALU_ARB_RR_EN.
// Latency: request accepted in cycle N, result presented with resp_valid in cycle N+2; issue interval >= 3 cycles.
// Backpressure: holds the response in RESP until resp_ready; no requester is granted until the FSM returns to IDLE.
module alu_arb_ctrl #(
  parameter int XLEN = 32,
  parameter int OP_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [OP_W-1:0] alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            busy
);
  import alu_arb_pkg::*;

  state_e          state, state_nxt;
  logic [1:0]      gnt;
  logic            take;
  logic            arb_en;
  logic [OP_W-1:0] op_sel, op_q;
  logic [XLEN-1:0] a_sel, b_sel, a_q, b_q;
  logic            legal_q, id_q;

  // Grants are only offered in IDLE and never while reset is asserted
  assign arb_en = (state == ST_IDLE) && !reset;
  assign take   = |gnt;

  alu_arb_rr u_arb (
`ifdef ALU_ARB_RR_EN
    .clk   (clk),
    .reset (reset),
`endif
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign op_sel  = gnt[1] ? req1_op : req0_op;
  assign a_sel   = gnt[1] ? req1_a  : req0_a;
  assign b_sel   = gnt[1] ? req1_b  : req0_b;
  assign resp_id = id_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state: one EXEC cycle, RESP held until the consumer takes it
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take)       state_nxt = ST_EXEC;
      ST_EXEC:                 state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // outputs: ALU sees the no-op encoding except in EXEC with a legal opcode
  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    busy       = (state != ST_IDLE);
    resp_valid = (state == ST_RESP);
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (state == ST_EXEC && legal_q) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
  end

  // latch the granted request, then capture the ALU result at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      legal_q   <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (take) begin
        op_q    <= op_sel;
        a_q     <= a_sel;
        b_q     <= b_sel;
        id_q    <= gnt[1];
        legal_q <= op_is_legal(op_sel[8:0]);
      end
      if (state == ST_EXEC) begin
        resp_data <= legal_q ? alu_rd : '0;
        resp_err  <= !legal_q;
      end
    end
  end

endmodule
